// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline memory stage.
package pipe_pkg;

    localparam int unsigned REGI_BITS_DEF   = 4;
    localparam int unsigned VECT_BITS_DEF   = 2;
    localparam int unsigned REGI_SIZE_DEF   = 16;
    localparam int unsigned VECT_SIZE_DEF   = 8;
    localparam int unsigned ELEM_SIZE_DEF   = 8;
    localparam int unsigned MEMO_LINES_DEF  = 64;
    localparam int unsigned ACK_TIMEOUT_DEF = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } memState_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts ACCESS cycles without an ack; expired marks the last allowed wait cycle.
module mem_timeout_ctr
    import pipe_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // Saturates so the count can never wrap back onto the expiry value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(ACK_TIMEOUT))) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results to writeback or runs one memory
// access with ack handshake, timeout and address/flag fault detection.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int unsigned REGI_BITS   = REGI_BITS_DEF,
    parameter int unsigned VECT_BITS   = VECT_BITS_DEF,
    parameter int unsigned REGI_SIZE   = REGI_SIZE_DEF,
    parameter int unsigned VECT_SIZE   = VECT_SIZE_DEF,
    parameter int unsigned ELEM_SIZE   = ELEM_SIZE_DEF,
    parameter int unsigned MEMO_LINES  = MEMO_LINES_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 valid_i,
    input  logic [REGI_SIZE-1:0]                 ialu_res_i,
    input  logic [ELEM_SIZE*VECT_SIZE-1:0]       valu_res_i,
    input  logic                                 flagMemRead_i,
    input  logic                                 flagMemWrite_i,
    input  logic                                 writeResultInt_i,
    input  logic                                 writeResultV_i,
    input  logic [REGI_BITS-1:0]                 intRegDest_i,
    input  logic [VECT_BITS-1:0]                 vecRegDest_i,
    output logic                                 mem_req_o,
    output logic                                 mem_we_o,
    output logic [$clog2(MEMO_LINES)-1:0]        mem_addr_o,
    output logic [ELEM_SIZE*VECT_SIZE-1:0]       mem_wdata_o,
    input  logic                                 mem_ack_i,
    input  logic [ELEM_SIZE*VECT_SIZE-1:0]       mem_rdata_i,
    output logic                                 stall_o,
    output logic                                 wb_valid_o,
    output logic                                 wb_int_we_o,
    output logic                                 wb_vec_we_o,
    output logic [REGI_SIZE-1:0]                 wb_int_data_o,
    output logic [ELEM_SIZE*VECT_SIZE-1:0]       wb_vec_data_o,
    output logic [REGI_BITS-1:0]                 wb_int_dest_o,
    output logic [VECT_BITS-1:0]                 wb_vec_dest_o,
    output logic                                 fault_o
);

    localparam int unsigned VEC_W  = ELEM_SIZE * VECT_SIZE;
    localparam int unsigned ADDR_W = $clog2(MEMO_LINES);

    memState_t state, stateNext;

    logic                 opWrite, opWriteNext;
    logic                 opWrInt, opWrIntNext;
    logic                 opWrVec, opWrVecNext;
    logic [REGI_BITS-1:0] opIntDest, opIntDestNext;
    logic [VECT_BITS-1:0] opVecDest, opVecDestNext;
    logic [ADDR_W-1:0]    addrNext;
    logic [VEC_W-1:0]     wdataNext;

    logic                 wbValidNext, wbIntWeNext, wbVecWeNext, faultNext;
    logic [REGI_SIZE-1:0] wbIntDataNext;
    logic [VEC_W-1:0]     wbVecDataNext;
    logic [REGI_BITS-1:0] wbIntDestNext;
    logic [VECT_BITS-1:0] wbVecDestNext;

    logic ctrClear, ctrEnable, ctrExpired;
    logic isMemOp, badMemOp;

    assign isMemOp  = flagMemRead_i || flagMemWrite_i;
    assign badMemOp = (flagMemRead_i && flagMemWrite_i) ||
                      (ialu_res_i >= REGI_SIZE'(MEMO_LINES));

    assign stall_o   = (state == ACCESS);
    assign mem_req_o = (state == ACCESS);
    assign mem_we_o  = (state == ACCESS) && opWrite;

    mem_timeout_ctr #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_timeout (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (ctrClear),
        .enable (ctrEnable),
        .expired(ctrExpired)
    );

    // Next-state, latched operation and registered writeback bundle.
    always_comb begin
        stateNext     = state;
        opWriteNext   = opWrite;
        opWrIntNext   = opWrInt;
        opWrVecNext   = opWrVec;
        opIntDestNext = opIntDest;
        opVecDestNext = opVecDest;
        addrNext      = mem_addr_o;
        wdataNext     = mem_wdata_o;
        wbValidNext   = 1'b0;
        wbIntWeNext   = 1'b0;
        wbVecWeNext   = 1'b0;
        wbIntDataNext = '0;
        wbVecDataNext = '0;
        wbIntDestNext = '0;
        wbVecDestNext = '0;
        faultNext     = 1'b0;
        ctrClear      = 1'b0;
        ctrEnable     = 1'b0;

        case (state)
            IDLE: begin
                if (valid_i) begin
                    if (!isMemOp) begin
                        wbValidNext   = 1'b1;
                        wbIntWeNext   = writeResultInt_i;
                        wbVecWeNext   = writeResultV_i;
                        wbIntDataNext = ialu_res_i;
                        wbVecDataNext = valu_res_i;
                        wbIntDestNext = intRegDest_i;
                        wbVecDestNext = vecRegDest_i;
                    end else if (badMemOp) begin
                        wbValidNext = 1'b1;
                        faultNext   = 1'b1;
                    end else begin
                        stateNext     = ACCESS;
                        ctrClear      = 1'b1;
                        opWriteNext   = flagMemWrite_i;
                        opWrIntNext   = writeResultInt_i;
                        opWrVecNext   = writeResultV_i;
                        opIntDestNext = intRegDest_i;
                        opVecDestNext = vecRegDest_i;
                        addrNext      = ialu_res_i[ADDR_W-1:0];
                        wdataNext     = valu_res_i;
                    end
                end
            end
            ACCESS: begin
                ctrEnable = !mem_ack_i;
                // Ack takes priority over an expiring timeout.
                if (mem_ack_i) begin
                    stateNext   = IDLE;
                    wbValidNext = 1'b1;
                    if (!opWrite) begin
                        wbIntWeNext   = opWrInt;
                        wbVecWeNext   = opWrVec;
                        wbIntDataNext = mem_rdata_i[REGI_SIZE-1:0];
                        wbVecDataNext = mem_rdata_i;
                        wbIntDestNext = opIntDest;
                        wbVecDestNext = opVecDest;
                    end
                end else if (ctrExpired) begin
                    stateNext   = IDLE;
                    wbValidNext = 1'b1;
                    faultNext   = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= IDLE;
            opWrite       <= 1'b0;
            opWrInt       <= 1'b0;
            opWrVec       <= 1'b0;
            opIntDest     <= '0;
            opVecDest     <= '0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            wb_valid_o    <= 1'b0;
            wb_int_we_o   <= 1'b0;
            wb_vec_we_o   <= 1'b0;
            wb_int_data_o <= '0;
            wb_vec_data_o <= '0;
            wb_int_dest_o <= '0;
            wb_vec_dest_o <= '0;
            fault_o       <= 1'b0;
        end else begin
            state         <= stateNext;
            opWrite       <= opWriteNext;
            opWrInt       <= opWrIntNext;
            opWrVec       <= opWrVecNext;
            opIntDest     <= opIntDestNext;
            opVecDest     <= opVecDestNext;
            mem_addr_o    <= addrNext;
            mem_wdata_o   <= wdataNext;
            wb_valid_o    <= wbValidNext;
            wb_int_we_o   <= wbIntWeNext;
            wb_vec_we_o   <= wbVecWeNext;
            wb_int_data_o <= wbIntDataNext;
            wb_vec_data_o <= wbVecDataNext;
            wb_int_dest_o <= wbIntDestNext;
            wb_vec_dest_o <= wbVecDestNext;
            fault_o       <= faultNext;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level model of the stage.
`timescale 1ns/1ps
module tb_mem_stage;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned LINES   = 64;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [15:0] ialu_res_i;
    logic [63:0] valu_res_i;
    logic        flagMemRead_i, flagMemWrite_i;
    logic        writeResultInt_i, writeResultV_i;
    logic [3:0]  intRegDest_i;
    logic [1:0]  vecRegDest_i;
    logic        mem_req_o, mem_we_o;
    logic [5:0]  mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [63:0] mem_rdata_i;
    logic        stall_o;
    logic        wb_valid_o, wb_int_we_o, wb_vec_we_o;
    logic [15:0] wb_int_data_o;
    logic [63:0] wb_vec_data_o;
    logic [3:0]  wb_int_dest_o;
    logic [1:0]  wb_vec_dest_o;
    logic        fault_o;

    mem_stage dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .valid_i         (valid_i),
        .ialu_res_i      (ialu_res_i),
        .valu_res_i      (valu_res_i),
        .flagMemRead_i   (flagMemRead_i),
        .flagMemWrite_i  (flagMemWrite_i),
        .writeResultInt_i(writeResultInt_i),
        .writeResultV_i  (writeResultV_i),
        .intRegDest_i    (intRegDest_i),
        .vecRegDest_i    (vecRegDest_i),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_ack_i       (mem_ack_i),
        .mem_rdata_i     (mem_rdata_i),
        .stall_o         (stall_o),
        .wb_valid_o      (wb_valid_o),
        .wb_int_we_o     (wb_int_we_o),
        .wb_vec_we_o     (wb_vec_we_o),
        .wb_int_data_o   (wb_int_data_o),
        .wb_vec_data_o   (wb_vec_data_o),
        .wb_int_dest_o   (wb_int_dest_o),
        .wb_vec_dest_o   (wb_vec_dest_o),
        .fault_o         (fault_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Model: an outstanding memory transaction and the expected writeback.
    logic        mBusy = 1'b0;
    int          mWait = 0;
    logic        mWrite = 1'b0, mWrInt = 1'b0, mWrVec = 1'b0;
    logic [3:0]  mIntDest = '0;
    logic [1:0]  mVecDest = '0;
    logic [5:0]  mAddr = '0;
    logic [63:0] mWdata = '0;
    logic        eWbValid = 1'b0, eIntWe = 1'b0, eVecWe = 1'b0, eFault = 1'b0;
    logic [15:0] eIntData = '0;
    logic [63:0] eVecData = '0;
    logic [3:0]  eIntDest = '0;
    logic [1:0]  eVecDest = '0;

    int          ackAt = 0;
    logic [63:0] plannedRdata = '0;
    logic        strayAck = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setIn(input logic v, input logic rd, input logic wr, input logic wi,
                         input logic wv, input logic [15:0] a, input logic [63:0] d,
                         input logic [3:0] id, input logic [1:0] vd);
        valid_i = v; flagMemRead_i = rd; flagMemWrite_i = wr;
        writeResultInt_i = wi; writeResultV_i = wv;
        ialu_res_i = a; valu_res_i = d; intRegDest_i = id; vecRegDest_i = vd;
    endtask

    // Predict the outputs after the coming edge from the current inputs.
    task automatic modelStep();
        eWbValid = 1'b0; eIntWe = 1'b0; eVecWe = 1'b0; eFault = 1'b0;
        if (!mBusy) begin
            if (valid_i) begin
                if (!flagMemRead_i && !flagMemWrite_i) begin
                    eWbValid = 1'b1;
                    eIntWe = writeResultInt_i; eVecWe = writeResultV_i;
                    eIntData = ialu_res_i; eVecData = valu_res_i;
                    eIntDest = intRegDest_i; eVecDest = vecRegDest_i;
                end else if ((flagMemRead_i && flagMemWrite_i) || (int'(ialu_res_i) >= int'(LINES))) begin
                    eWbValid = 1'b1; eFault = 1'b1;
                end else begin
                    mBusy = 1'b1; mWait = 0;
                    mWrite = flagMemWrite_i; mWrInt = writeResultInt_i; mWrVec = writeResultV_i;
                    mIntDest = intRegDest_i; mVecDest = vecRegDest_i;
                    mAddr = ialu_res_i[5:0]; mWdata = valu_res_i;
                end
            end
        end else if (mem_ack_i) begin
            mBusy = 1'b0; eWbValid = 1'b1;
            if (!mWrite) begin
                eIntWe = mWrInt; eVecWe = mWrVec;
                eIntData = mem_rdata_i[15:0]; eVecData = mem_rdata_i;
                eIntDest = mIntDest; eVecDest = mVecDest;
            end
        end else begin
            mWait++;
            if (mWait == int'(TIMEOUT)) begin
                mBusy = 1'b0; eWbValid = 1'b1; eFault = 1'b1;
            end
        end
    endtask

    task automatic compareAll();
        chk("stall", 64'(stall_o), 64'(mBusy));
        chk("mem_req", 64'(mem_req_o), 64'(mBusy));
        chk("mem_we", 64'(mem_we_o), 64'(mBusy && mWrite));
        if (mBusy) begin
            chk("mem_addr", 64'(mem_addr_o), 64'(mAddr));
            chk("mem_wdata", mem_wdata_o, mWdata);
        end
        chk("wb_valid", 64'(wb_valid_o), 64'(eWbValid));
        chk("wb_int_we", 64'(wb_int_we_o), 64'(eIntWe));
        chk("wb_vec_we", 64'(wb_vec_we_o), 64'(eVecWe));
        chk("fault", 64'(fault_o), 64'(eFault));
        if (eIntWe) begin
            chk("wb_int_data", 64'(wb_int_data_o), 64'(eIntData));
            chk("wb_int_dest", 64'(wb_int_dest_o), 64'(eIntDest));
        end
        if (eVecWe) begin
            chk("wb_vec_data", wb_vec_data_o, eVecData);
            chk("wb_vec_dest", 64'(wb_vec_dest_o), 64'(eVecDest));
        end
    endtask

    task automatic step();
        if (mBusy) begin
            mem_ack_i   = ((mWait + 1) == ackAt);
            mem_rdata_i = mem_ack_i ? plannedRdata : {$urandom, $urandom};
        end else begin
            mem_ack_i   = strayAck;
            mem_rdata_i = {$urandom, $urandom};
        end
        modelStep();
        @(posedge clk_i);
        #1;
        compareAll();
    endtask

    task automatic checkZero(input string tag);
        chk({tag, "_req"}, 64'(mem_req_o), 64'd0);
        chk({tag, "_we"}, 64'(mem_we_o), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr_o), 64'd0);
        chk({tag, "_wdata"}, mem_wdata_o, 64'd0);
        chk({tag, "_stall"}, 64'(stall_o), 64'd0);
        chk({tag, "_wbv"}, 64'(wb_valid_o), 64'd0);
        chk({tag, "_iwe"}, 64'(wb_int_we_o), 64'd0);
        chk({tag, "_vwe"}, 64'(wb_vec_we_o), 64'd0);
        chk({tag, "_idata"}, 64'(wb_int_data_o), 64'd0);
        chk({tag, "_vdata"}, wb_vec_data_o, 64'd0);
        chk({tag, "_idest"}, 64'(wb_int_dest_o), 64'd0);
        chk({tag, "_vdest"}, 64'(wb_vec_dest_o), 64'd0);
        chk({tag, "_fault"}, 64'(fault_o), 64'd0);
    endtask

    // Runs ACCESS cycles until stall drops; returns how many were observed.
    task automatic countStall(output int n);
        n = 0;
        while (stall_o && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic intOp027();
        setIn(1, 0, 0, 1, 0, 16'h1234, 64'h0, 4'd3, 2'd0);
        step();
        chk("int_wbv", 64'(wb_valid_o), 64'd1);
        chk("int_we", 64'(wb_int_we_o), 64'd1);
        chk("int_data", 64'(wb_int_data_o), 64'h1234);
        chk("int_dest", 64'(wb_int_dest_o), 64'd3);
        chk("int_stall", 64'(stall_o), 64'd0);
        setIn(0, 0, 0, 0, 0, 16'h0, 64'h0, 4'd0, 2'd0);
        step();
    endtask

    function automatic int pickAckAt();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r == 1) return int'(TIMEOUT);
        if (r == 2) return int'(TIMEOUT) - 1;
        return int'($urandom_range(1, 5));
    endfunction

    initial begin
        int n;
        rst_i = 1'b1;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        setIn(0, 0, 0, 0, 0, 16'h0, 64'h0, 4'd0, 2'd0);
        #1 rst_i = 1'b0;
        #1 checkZero("reset");
        @(posedge clk_i);
        #1 rst_i = 1'b1;

        intOp027();

        // Load at line 10, acked in the third ACCESS cycle.
        ackAt = 3;
        plannedRdata = 64'hA5A5_0000_FFFF_0102;
        setIn(1, 1, 0, 0, 1, 16'd10, 64'h0, 4'd0, 2'd2);
        step();
        chk("ld_addr", 64'(mem_addr_o), 64'd10);
        chk("ld_we", 64'(mem_we_o), 64'd0);
        setIn(0, 0, 0, 0, 0, 16'h0, 64'h0, 4'd0, 2'd0);
        countStall(n);
        chk("ld_stall_cycles", 64'(n), 64'd3);
        chk("ld_vdata", wb_vec_data_o, 64'hA5A5_0000_FFFF_0102);
        chk("ld_vwe", 64'(wb_vec_we_o), 64'd1);
        chk("ld_iwe", 64'(wb_int_we_o), 64'd0);

        // Store at line 5, acked in the first ACCESS cycle.
        ackAt = 1;
        setIn(1, 0, 1, 1, 1, 16'd5, 64'h0102030405060708, 4'd1, 2'd1);
        step();
        chk("st_we", 64'(mem_we_o), 64'd1);
        chk("st_wdata", mem_wdata_o, 64'h0102030405060708);
        setIn(0, 0, 0, 0, 0, 16'h0, 64'h0, 4'd0, 2'd0);
        step();
        chk("st_wbv", 64'(wb_valid_o), 64'd1);
        chk("st_iwe", 64'(wb_int_we_o), 64'd0);
        chk("st_vwe", 64'(wb_vec_we_o), 64'd0);

        // Load with no ack at all.
        ackAt = 0;
        setIn(1, 1, 0, 1, 1, 16'd33, 64'h0, 4'd2, 2'd3);
        step();
        setIn(0, 0, 0, 0, 0, 16'h0, 64'h0, 4'd0, 2'd0);
        countStall(n);
        chk("to_stall_cycles", 64'(n), 64'd16);
        chk("to_fault", 64'(fault_o), 64'd1);
        chk("to_req", 64'(mem_req_o), 64'd0);
        chk("to_iwe", 64'(wb_int_we_o), 64'd0);
        step();
        chk("to_fault_pulse", 64'(fault_o), 64'd0);

        // Ack arriving on the timeout cycle completes normally.
        ackAt = 16;
        plannedRdata = 64'h1111_2222_3333_4444;
        setIn(1, 1, 0, 1, 0, 16'd63, 64'h0, 4'd9, 2'd0);
        step();
        setIn(0, 0, 0, 0, 0, 16'h0, 64'h0, 4'd0, 2'd0);
        countStall(n);
        chk("late_stall_cycles", 64'(n), 64'd16);
        chk("late_fault", 64'(fault_o), 64'd0);
        chk("late_idata", 64'(wb_int_data_o), 64'h4444);

        // Out-of-range address and conflicting flags.
        setIn(1, 1, 0, 1, 1, 16'd64, 64'h0, 4'd0, 2'd0);
        step();
        chk("oor_req", 64'(mem_req_o), 64'd0);
        chk("oor_fault", 64'(fault_o), 64'd1);
        setIn(1, 1, 1, 1, 1, 16'd5, 64'h0, 4'd0, 2'd0);
        step();
        chk("both_req", 64'(mem_req_o), 64'd0);
        chk("both_fault", 64'(fault_o), 64'd1);

        // Reset in the middle of an access.
        ackAt = 0;
        setIn(1, 1, 0, 0, 1, 16'd7, 64'h0, 4'd0, 2'd0);
        step();
        setIn(0, 0, 0, 0, 0, 16'h0, 64'h0, 4'd0, 2'd0);
        step();
        #2 rst_i = 1'b0;
        #1;
        chk("mid_rst_req", 64'(mem_req_o), 64'd0);
        chk("mid_rst_stall", 64'(stall_o), 64'd0);
        chk("mid_rst_wbv", 64'(wb_valid_o), 64'd0);
        mBusy = 1'b0; mWait = 0;
        @(posedge clk_i);
        #1 checkZero("rst_hold");
        rst_i = 1'b1;
        intOp027();

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            int r;
            logic rd, wr;
            r = int'($urandom_range(0, 9));
            rd = (r >= 4 && r <= 6) || r == 9;
            wr = (r == 7 || r == 8) || r == 9;
            setIn($urandom_range(0, 3) != 0, rd, wr, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 4) == 0) ? 16'($urandom_range(64, 65535)) : 16'($urandom_range(0, 63)),
                  {$urandom, $urandom}, 4'($urandom), 2'($urandom));
            if (!mBusy) begin
                strayAck = ($urandom_range(0, 3) == 0);
                ackAt = pickAckAt();
                plannedRdata = {$urandom, $urandom};
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
